// File: rtl/itim_refill_ctrl.sv
// ITIM refill/fence sequencer: fills one line from imem on a miss, or invalidates all unlocked sets on a fence.
// Latency: refill = 2**itim_width accepted words + 1 write cycle; fence = 2**itim_depth + 1 cycles after the request.
// Backpressure: mem_ready low stalls the refill with mem_addr held; requests arriving while busy wait until IDLE.
module itim_refill_ctrl #(
  parameter int itim_depth = 4,
  parameter int itim_width = 2,
  localparam int T = 30 - (itim_depth + itim_width),
  localparam int L = (2 ** itim_width) * 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_valid,
  input  logic [31:0]           miss_addr,
  input  logic                  fence_valid,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           miss_rdata,
  output logic                  mem_valid,
  output logic [31:0]           mem_addr,
  input  logic                  mem_ready,
  input  logic [31:0]           mem_rdata,
  output logic                  tag_wen,
  output logic [itim_depth-1:0] tag_waddr,
  output logic [T-1:0]          tag_wdata,
  output logic                  data_wen,
  output logic [itim_depth-1:0] data_waddr,
  output logic [L-1:0]          data_wdata,
  output logic                  valid_wen,
  output logic [itim_depth-1:0] valid_waddr,
  output logic                  valid_wdata,
  output logic [itim_depth-1:0] lock_raddr,
  input  logic                  lock_rdata
);

  typedef enum logic [1:0] {IDLE, REFILL, WRITE, FENCE} state_t;

  state_t                  state, state_n;
  logic [T-1:0]            tag_q;
  logic [itim_depth-1:0]   did_q;
  logic [itim_width-1:0]   wid_q;
  logic [29-itim_width:0]  base_q;
  logic [itim_width-1:0]   word_cnt;
  // One extra bit: the walk needs one more cycle than there are sets to retire the last lock read.
  logic [itim_depth:0]     set_cnt;
  logic [L-1:0]            line_buf;

  // Byte offset never matters for a word-granular refill.
  logic unused_byte_off;
  assign unused_byte_off = ^miss_addr[1:0];

  // State register; reset aborts any refill or fence in progress.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Request capture, word/set counters and the line buffer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tag_q    <= '0;
      did_q    <= '0;
      wid_q    <= '0;
      base_q   <= '0;
      word_cnt <= '0;
      set_cnt  <= '0;
      line_buf <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fence_valid) begin
            set_cnt <= '0;
          end else if (miss_valid) begin
            tag_q    <= miss_addr[31:itim_depth+itim_width+2];
            did_q    <= miss_addr[itim_depth+itim_width+1:itim_width+2];
            wid_q    <= miss_addr[itim_width+1:2];
            base_q   <= miss_addr[31:itim_width+2];
            word_cnt <= '0;
          end
        end
        REFILL: begin
          if (mem_ready) begin
            line_buf[word_cnt*32 +: 32] <= mem_rdata;
            word_cnt                    <= word_cnt + 1'b1;
          end
        end
        FENCE: set_cnt <= set_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Next state and all outputs; everything idles at zero outside its own state.
  always_comb begin
    state_n     = state;
    busy        = (state != IDLE);
    done        = 1'b0;
    miss_rdata  = '0;
    mem_valid   = 1'b0;
    mem_addr    = '0;
    tag_wen     = 1'b0;
    tag_waddr   = '0;
    tag_wdata   = '0;
    data_wen    = 1'b0;
    data_waddr  = '0;
    data_wdata  = '0;
    valid_wen   = 1'b0;
    valid_waddr = '0;
    valid_wdata = 1'b0;
    lock_raddr  = '0;
    case (state)
      IDLE: begin
        if (fence_valid)     state_n = FENCE;
        else if (miss_valid) state_n = REFILL;
      end
      REFILL: begin
        mem_valid = 1'b1;
        mem_addr  = {base_q, word_cnt, 2'b00};
        if (mem_ready && (word_cnt == {itim_width{1'b1}})) state_n = WRITE;
      end
      WRITE: begin
        tag_wen     = 1'b1;
        tag_waddr   = did_q;
        tag_wdata   = tag_q;
        data_wen    = 1'b1;
        data_waddr  = did_q;
        data_wdata  = line_buf;
        valid_wen   = 1'b1;
        valid_waddr = did_q;
        valid_wdata = 1'b1;
        done        = 1'b1;
        miss_rdata  = line_buf[wid_q*32 +: 32];
        state_n     = IDLE;
      end
      FENCE: begin
        // Read lock for set k this cycle, clear set k-1 using the lock bit read last cycle.
        lock_raddr = set_cnt[itim_depth-1:0];
        if (set_cnt != '0) begin
          valid_waddr = set_cnt[itim_depth-1:0] - 1'b1;
          valid_wen   = !lock_rdata;
        end
        if (set_cnt[itim_depth]) begin
          done    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
